draw_arbiter: RTL

DRAW_ARBITER -- requirements
Module: draw_arbiter

---
 rtl/draw_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/draw_arbiter.sv
// Three-requester pixel arbiter for a shared VGA adapter port.
// Non-preemptive bursts with a one-cycle release gap, a frame-gated car requester and a burst watchdog.
module draw_arbiter #(
    parameter logic [19:0] TIMEOUT = 20'd153_600
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        frameTick,
    input  logic [2:0]  req,
    input  logic [2:0]  reqValid,
    input  logic [2:0]  reqLast,
    input  logic [26:0] xBus,
    input  logic [23:0] yBus,
    input  logic [17:0] cBus,
    output logic [2:0]  grant,
    output logic [8:0]  xDisplay,
    output logic [7:0]  yDisplay,
    output logic [5:0]  colourDisplay,
    output logic        plotDisplay,
    output logic        busy,
    output logic        timeoutErr
);

    typedef enum logic [1:0] {IDLE, BURST, RELEASE} StateT;

    StateT       state;
    logic        carPending;
    logic [19:0] burstCnt;

    logic [2:0]  eligible;
    logic [2:0]  pick;
    logic [8:0]  gX;
    logic [7:0]  gY;
    logic [5:0]  gC;
    logic        gValid;
    logic        gLast;
    logic        gReq;

    // The car requester only competes in a frame that has ticked since its last grant.
    assign eligible = {req[2], req[1] & (carPending | frameTick), req[0]};

    always_comb begin
        pick = 3'b000;
        if (eligible[0])      pick = 3'b001;
        else if (eligible[1]) pick = 3'b010;
        else if (eligible[2]) pick = 3'b100;
    end

    always_comb begin
        gX = '0;
        gY = '0;
        gC = '0;
        for (int i = 0; i < 3; i++) begin
            if (grant[i]) begin
                gX = gX | xBus[9*i +: 9];
                gY = gY | yBus[8*i +: 8];
                gC = gC | cBus[6*i +: 6];
            end
        end
    end

    assign gValid = |(reqValid & grant);
    assign gLast  = |(reqValid & reqLast & grant);
    assign gReq   = |(req & grant);
    assign busy   = (state != IDLE);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state         <= IDLE;
            grant         <= 3'b000;
            carPending    <= 1'b0;
            burstCnt      <= '0;
            timeoutErr    <= 1'b0;
            plotDisplay   <= 1'b0;
            xDisplay      <= '0;
            yDisplay      <= '0;
            colourDisplay <= '0;
        end else begin
            plotDisplay <= 1'b0;
            if (frameTick) carPending <= 1'b1;
            case (state)
                IDLE: begin
                    if (|pick) begin
                        grant    <= pick;
                        state    <= BURST;
                        burstCnt <= '0;
                        if (pick[1]) carPending <= 1'b0;
                    end
                end
                BURST: begin
                    burstCnt <= burstCnt + 20'd1;
                    if (gLast) begin
                        plotDisplay   <= 1'b1;
                        xDisplay      <= gX;
                        yDisplay      <= gY;
                        colourDisplay <= gC;
                        grant         <= 3'b000;
                        state         <= RELEASE;
                    end else if (!gReq) begin
                        grant <= 3'b000;
                        state <= RELEASE;
                    end else if (burstCnt == TIMEOUT - 20'd1) begin
                        // Watchdog revoke: the pixel offered on this cycle is dropped.
                        grant      <= 3'b000;
                        state      <= RELEASE;
                        timeoutErr <= 1'b1;
                    end else if (gValid) begin
                        plotDisplay   <= 1'b1;
                        xDisplay      <= gX;
                        yDisplay      <= gY;
                        colourDisplay <= gC;
                    end
                end
                RELEASE: state <= IDLE;
                default: begin
                    state <= IDLE;
                    grant <= 3'b000;
                end
            endcase
        end
    end

endmodule
